// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : perf_counter_bank
//  Purpose  : Bank of per-event performance counters fed by 1-bit strobes,
//             with a valid/ready read port, read-to-clear, sticky overflow,
//             wrap or saturate mode, global freeze/clear and an overflow IRQ.
//  Ports    : clock, reset (async, active-low)
//             event_i / enable_i / freeze_i / clear_i  - counting control
//             irq_en_i, irq_o, ovf_any_o                - overflow reporting
//             rd_valid_i / rd_ready_o / rd_idx_i / rd_clr_i - read request
//             resp_valid_o / resp_ready_i / resp_data_o /
//             resp_ovf_o / resp_err_o                   - read response
//  Revision : 1.0  initial release
// ============================================================================
module perf_counter_bank #(
   parameter int NUM_EVENTS = 6,
   parameter int CNT_W      = 64,
   parameter bit SATURATE   = 1'b0,
   parameter int IDX_W      = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_EVENTS-1:0] event_i,
   input  logic                  enable_i,
   input  logic                  freeze_i,
   input  logic                  clear_i,
   input  logic                  irq_en_i,
   input  logic                  rd_valid_i,
   output logic                  rd_ready_o,
   input  logic [IDX_W-1:0]      rd_idx_i,
   input  logic                  rd_clr_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [CNT_W-1:0]      resp_data_o,
   output logic                  resp_ovf_o,
   output logic                  resp_err_o,
   output logic                  ovf_any_o,
   output logic                  irq_o
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt [NUM_EVENTS];
   logic [NUM_EVENTS-1:0]   ovf;
   logic                    accept;
   logic                    idx_hit;
   logic [CNT_W-1:0]        sel_cnt;
   logic                    sel_ovf;
   logic [NUM_EVENTS-1:0]   rd_clr_hit;
   logic [NUM_EVENTS-1:0]   count_en;

   assign accept   = rd_valid_i & rd_ready_o;
   assign count_en = event_i & {NUM_EVENTS{enable_i & ~freeze_i}};

   // Index decode: selects the addressed counter and flags an out-of-range
   // index (no match) so it can neither be read nor cleared.
   always_comb begin
      idx_hit    = 1'b0;
      sel_cnt    = '0;
      sel_ovf    = 1'b0;
      rd_clr_hit = '0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         if (rd_idx_i == IDX_W'(i)) begin
            idx_hit       = 1'b1;
            sel_cnt       = cnt[i];
            sel_ovf       = ovf[i];
            rd_clr_hit[i] = accept & rd_clr_i;
         end
      end
   end

   // Counter bank. Priority: global clear, then read-to-clear (which keeps
   // an event arriving in the same cycle), then normal increment.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_EVENTS; i++) begin
            cnt[i] <= '0;
         end
         ovf <= '0;
      end else begin
         for (int i = 0; i < NUM_EVENTS; i++) begin
            if (clear_i) begin
               cnt[i] <= '0;
               ovf[i] <= 1'b0;
            end else if (rd_clr_hit[i]) begin
               cnt[i] <= count_en[i] ? CNT_W'(1) : '0;
               ovf[i] <= 1'b0;
            end else if (count_en[i]) begin
               if (&cnt[i]) begin
                  ovf[i] <= 1'b1;
                  cnt[i] <= SATURATE ? cnt[i] : '0;
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end
         end
      end
   end

   assign ovf_any_o = |ovf;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         irq_o <= 1'b0;
      end else begin
         irq_o <= ovf_any_o & irq_en_i;
      end
   end

   // Read FSM: one outstanding request. Response fields are captured from the
   // register values in the acceptance cycle and held until consumed.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         rd_ready_o   <= 1'b1;
         resp_valid_o <= 1'b0;
         resp_data_o  <= '0;
         resp_ovf_o   <= 1'b0;
         resp_err_o   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state        <= ST_RESP;
                  rd_ready_o   <= 1'b0;
                  resp_valid_o <= 1'b1;
                  resp_data_o  <= idx_hit ? sel_cnt : '0;
                  resp_ovf_o   <= idx_hit & sel_ovf;
                  resp_err_o   <= ~idx_hit;
               end
            end
            ST_RESP: begin
               if (resp_ready_i) begin
                  state        <= ST_IDLE;
                  rd_ready_o   <= 1'b1;
                  resp_valid_o <= 1'b0;
               end
            end
            default: begin
               state        <= ST_IDLE;
               rd_ready_o   <= 1'b1;
               resp_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_perf_counter_bank
//  Purpose  : Self-checking bench for perf_counter_bank. Two 8-bit instances
//             (wrap and saturate) share one stimulus; a behavioural model is
//             compared against both on every falling edge, and directed
//             literal expectations pin the model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_perf_counter_bank;

   logic       clk;
   logic       rst_n;
   logic [5:0] ev;
   logic       enable, freeze, clear, irq_en;
   logic       rd_valid, rd_clr, resp_ready;
   logic [4:0] rd_idx;

   logic       rdy_w, rv_w, rov_w, err_w, any_w, irq_w;
   logic       rdy_s, rv_s, rov_s, err_s, any_s, irq_s;
   logic [7:0] data_w, data_s;

   int n_checks = 0;
   int n_fail   = 0;
   bit started  = 0;

   perf_counter_bank #(.NUM_EVENTS(6), .CNT_W(8), .SATURATE(1'b0), .IDX_W(5)) dut_w (
      .clock(clk), .reset(rst_n), .event_i(ev), .enable_i(enable), .freeze_i(freeze),
      .clear_i(clear), .irq_en_i(irq_en), .rd_valid_i(rd_valid), .rd_ready_o(rdy_w),
      .rd_idx_i(rd_idx), .rd_clr_i(rd_clr), .resp_valid_o(rv_w), .resp_ready_i(resp_ready),
      .resp_data_o(data_w), .resp_ovf_o(rov_w), .resp_err_o(err_w), .ovf_any_o(any_w),
      .irq_o(irq_w));

   perf_counter_bank #(.NUM_EVENTS(6), .CNT_W(8), .SATURATE(1'b1), .IDX_W(5)) dut_s (
      .clock(clk), .reset(rst_n), .event_i(ev), .enable_i(enable), .freeze_i(freeze),
      .clear_i(clear), .irq_en_i(irq_en), .rd_valid_i(rd_valid), .rd_ready_o(rdy_s),
      .rd_idx_i(rd_idx), .rd_clr_i(rd_clr), .resp_valid_o(rv_s), .resp_ready_i(resp_ready),
      .resp_data_o(data_s), .resp_ovf_o(rov_s), .resp_err_o(err_s), .ovf_any_o(any_s),
      .irq_o(irq_s));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: counters as plain integers, limit by arithmetic.
   // ------------------------------------------------------------------
   int m_cw [6];
   int m_cs [6];
   bit m_ow [6];
   bit m_os [6];
   bit m_rdy, m_rv, m_rovw, m_rovs, m_err, m_irqw, m_irqs;
   int m_dw, m_ds;

   always @(posedge clk or negedge rst_n) begin
      bit acc, hit, inc, ow_any, os_any;
      if (!rst_n) begin
         for (int i = 0; i < 6; i++) begin
            m_cw[i] <= 0; m_cs[i] <= 0; m_ow[i] <= 0; m_os[i] <= 0;
         end
         m_rdy <= 1; m_rv <= 0; m_dw <= 0; m_ds <= 0;
         m_rovw <= 0; m_rovs <= 0; m_err <= 0; m_irqw <= 0; m_irqs <= 0;
      end else begin
         acc = rd_valid && m_rdy;
         hit = (rd_idx < 6);
         ow_any = 0;
         os_any = 0;
         for (int i = 0; i < 6; i++) begin
            ow_any = ow_any | m_ow[i];
            os_any = os_any | m_os[i];
         end
         m_irqw <= ow_any && irq_en;
         m_irqs <= os_any && irq_en;
         if (m_rdy) begin
            if (acc) begin
               m_rdy <= 0; m_rv <= 1; m_err <= !hit;
               m_dw <= 0; m_ds <= 0; m_rovw <= 0; m_rovs <= 0;
               for (int i = 0; i < 6; i++) begin
                  if (hit && rd_idx == i) begin
                     m_dw <= m_cw[i]; m_ds <= m_cs[i];
                     m_rovw <= m_ow[i]; m_rovs <= m_os[i];
                  end
               end
            end
         end else if (resp_ready) begin
            m_rdy <= 1; m_rv <= 0;
         end
         for (int i = 0; i < 6; i++) begin
            inc = ev[i] && enable && !freeze;
            if (clear) begin
               m_cw[i] <= 0; m_cs[i] <= 0; m_ow[i] <= 0; m_os[i] <= 0;
            end else if (acc && rd_clr && hit && rd_idx == i) begin
               m_cw[i] <= inc ? 1 : 0; m_cs[i] <= inc ? 1 : 0;
               m_ow[i] <= 0; m_os[i] <= 0;
            end else if (inc) begin
               m_cw[i] <= (m_cw[i] + 1) % 256;
               if (m_cw[i] + 1 == 256) m_ow[i] <= 1;
               m_cs[i] <= (m_cs[i] + 1 > 255) ? 255 : m_cs[i] + 1;
               if (m_cs[i] + 1 > 255) m_os[i] <= 1;
            end
         end
      end
   end

   // Compare process: every falling edge once reset has been applied.
   always @(negedge clk) begin
      bit ew, es;
      if (started) begin
         ew = 0;
         es = 0;
         for (int i = 0; i < 6; i++) begin
            ew = ew | m_ow[i];
            es = es | m_os[i];
         end
         chk("rd_ready_w", rdy_w, m_rdy);     chk("rd_ready_s", rdy_s, m_rdy);
         chk("resp_valid_w", rv_w, m_rv);     chk("resp_valid_s", rv_s, m_rv);
         chk("resp_data_w", data_w, m_dw);    chk("resp_data_s", data_s, m_ds);
         chk("resp_ovf_w", rov_w, m_rovw);    chk("resp_ovf_s", rov_s, m_rovs);
         chk("resp_err_w", err_w, m_err);     chk("resp_err_s", err_s, m_err);
         chk("ovf_any_w", any_w, ew);         chk("ovf_any_s", any_s, es);
         chk("irq_w", irq_w, m_irqw);         chk("irq_s", irq_s, m_irqs);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one read from IDLE; events ev_acc are present only in the
   // acceptance cycle. Returns the captured response of both instances.
   task automatic do_read(input int idx, input bit clr, input logic [5:0] ev_acc,
                          output logic [7:0] dw, output logic [7:0] ds,
                          output logic ow, output logic os, output logic er);
      int n;
      rd_valid = 1'b1; rd_idx = idx[4:0]; rd_clr = clr; ev = ev_acc;
      n = 0;
      while (!rdy_w && n < 10) begin tick(); n++; end
      chk("req_accept_bound", n, 0);
      tick();
      rd_valid = 1'b0; rd_clr = 1'b0; ev = '0;
      n = 0;
      while (!rv_w && n < 10) begin tick(); n++; end
      chk("resp_latency", n, 0);
      dw = data_w; ds = data_s; ow = rov_w; os = rov_s; er = err_w;
      tick();
   endtask

   logic [7:0] dw, ds, hold_d;
   logic       ow, os, er;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b1; ev = '0; enable = 1'b0; freeze = 1'b0; clear = 1'b0; irq_en = 1'b0;
      rd_valid = 1'b0; rd_clr = 1'b0; resp_ready = 1'b1; rd_idx = '0;
      #2 rst_n = 1'b0;
      #1 started = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_rd_ready", rdy_w, 1);
      chk("reset_resp_valid", rv_w, 0);
      chk("reset_irq", irq_w, 0);
      tick();
      rst_n = 1'b1;

      // 1: ten events on channel 0, then frozen events must not count
      enable = 1'b1;
      ev = 6'h01;
      repeat (10) tick();
      freeze = 1'b1;
      repeat (3) tick();
      freeze = 1'b0; ev = '0;
      do_read(0, 0, '0, dw, ds, ow, os, er);
      chk("t1_data", dw, 10); chk("t1_ovf", ow, 0); chk("t1_err", er, 0);

      // 2: 256 events on channel 2 wrap the 8-bit counter
      irq_en = 1'b1;
      ev = 6'h04;
      repeat (256) tick();
      ev = '0;
      @(negedge clk);
      chk("t2_ovf_any_w", any_w, 1); chk("t2_ovf_any_s", any_s, 1); chk("t2_irq_early", irq_w, 0);
      @(negedge clk);
      chk("t2_irq_w", irq_w, 1); chk("t2_irq_s", irq_s, 1);
      tick();
      do_read(2, 0, '0, dw, ds, ow, os, er);
      chk("t2_data_w", dw, 0); chk("t2_ovf_w", ow, 1);
      chk("t2_data_s", ds, 8'hFF); chk("t2_ovf_s", os, 1);

      // 3: up to 300 then 310 events: saturating copy stays at all-ones
      ev = 6'h04;
      repeat (44) tick();
      ev = '0;
      do_read(2, 0, '0, dw, ds, ow, os, er);
      chk("t3_data_s300", ds, 8'hFF); chk("t3_ovf_s300", os, 1); chk("t3_data_w300", dw, 44);
      ev = 6'h04;
      repeat (10) tick();
      ev = '0;
      do_read(2, 0, '0, dw, ds, ow, os, er);
      chk("t3_data_s310", ds, 8'hFF); chk("t3_data_w310", dw, 54);

      // 4: read-to-clear with a same-cycle event keeps that event
      ev = 6'h02;
      repeat (5) tick();
      ev = '0;
      do_read(1, 1, 6'h02, dw, ds, ow, os, er);
      chk("t4_rc_data", dw, 5);
      do_read(1, 0, '0, dw, ds, ow, os, er);
      chk("t4_after_rc", dw, 1);
      ev = 6'h02;
      repeat (2) tick();
      ev = '0;
      do_read(1, 0, '0, dw, ds, ow, os, er);
      chk("t4_later", dw, 3);

      // 5: response back-pressure while events continue
      ev = 6'h08;
      repeat (3) tick();
      resp_ready = 1'b0; rd_valid = 1'b1; rd_idx = 5'd3; rd_clr = 1'b0;
      tick();
      rd_valid = 1'b0;
      hold_d = data_w;
      chk("t5_capture", hold_d, 3);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t5_hold_data", data_w, hold_d);
         chk("t5_hold_ready", rdy_w, 0);
         chk("t5_hold_valid", rv_w, 1);
         tick();
      end
      resp_ready = 1'b1;
      tick();
      ev = '0;
      do_read(31, 1, '0, dw, ds, ow, os, er);
      chk("t5_err", er, 1); chk("t5_err_data", dw, 0); chk("t5_err_ovf", ow, 0);
      do_read(3, 0, '0, dw, ds, ow, os, er);
      chk("t5_cnt3", dw, 9);

      // 6: global clear beats events and read-to-clear in the same cycle
      clear = 1'b1; ev = 6'h3F; rd_valid = 1'b1; rd_idx = 5'd0; rd_clr = 1'b1;
      tick();
      clear = 1'b0; ev = '0; rd_valid = 1'b0; rd_clr = 1'b0;
      @(negedge clk);
      chk("t6_pre_clear_data", data_w, 10);
      chk("t6_ovf_any", any_w, 0);
      chk("t6_irq_lag", irq_w, 1);
      @(negedge clk);
      chk("t6_irq_drop", irq_w, 0);
      tick();
      do_read(2, 0, '0, dw, ds, ow, os, er);
      chk("t6_cnt2", dw, 0); chk("t6_ovf2", ow, 0);
      do_read(0, 0, '0, dw, ds, ow, os, er);
      chk("t6_cnt0", dw, 0);

      // Reset in the middle of a pending response
      ev = 6'h10;
      repeat (4) tick();
      ev = '0;
      rd_valid = 1'b1; rd_idx = 5'd4; resp_ready = 1'b0;
      tick();
      rd_valid = 1'b0;
      chk("t6_resp_pending", rv_w, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_reset_valid_w", rv_w, 0);
      chk("t6_reset_valid_s", rv_s, 0);
      chk("t6_reset_ready", rdy_w, 1);
      tick();
      tick();
      rst_n = 1'b1; resp_ready = 1'b1;
      do_read(4, 0, '0, dw, ds, ow, os, er);
      chk("t6_after_reset", dw, 0);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
